fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 38 +++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, BTB-update, instruction-memory and decode signals.
// The fetch stage sits on the slave side. The surrounding pipeline or a bench sits on the master side.
interface fetch_stage_if;
    logic        i_stall_fetch;
    logic        i_flush_decode;
    logic        i_redirect_execute;
    logic [31:0] i_redirect_pc;
    logic        i_update_vld;
    logic [31:0] i_update_pc;
    logic        i_update_taken;
    logic [31:0] i_update_target;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_pc_decode;
    logic [31:0] o_instr_decode;
    logic        o_pred_taken_decode;
    logic [31:0] o_pred_target_decode;
    logic        o_insn_vld_decode;

    // Control and memory inputs are level signals sampled on every rising edge.
    // There is no valid/ready pairing: the decode register always accepts its next value
    // unless i_stall_fetch holds it.
    modport slave (
        input  i_stall_fetch, i_flush_decode, i_redirect_execute, i_redirect_pc,
        input  i_update_vld, i_update_pc, i_update_taken, i_update_target,
        input  i_imem_rdata,
        output o_imem_addr, o_pc_decode, o_instr_decode,
        output o_pred_taken_decode, o_pred_target_decode, o_insn_vld_decode
    );

    modport master (
        output i_stall_fetch, i_flush_decode, i_redirect_execute, i_redirect_pc,
        output i_update_vld, i_update_pc, i_update_taken, i_update_target,
        output i_imem_rdata,
        input  o_imem_addr, o_pc_decode, o_instr_decode,
        input  o_pred_taken_decode, o_pred_target_decode, o_insn_vld_decode
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, direct-mapped BTB with 2-bit counters,
// and the fetch/decode pipeline register.
module fetch_stage #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_stage_if.slave  bus
);
    localparam int          IDX_W = $clog2(BTB_ENTRIES);
    localparam int          TAG_W = 30 - IDX_W;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]            pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] btb_vld_q;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [29:0]            btb_tgt_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q [BTB_ENTRIES];

    logic [31:0] dec_pc_q, dec_instr_q, dec_tgt_q;
    logic        dec_pt_q, dec_vld_q;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, pred_taken;
    logic [31:0]      pred_target;
    logic [1:0]       up_ctr_d;
    logic [31:0]      redirect_pc, update_tgt;
    logic             unused_low_bits;

    assign redirect_pc = bus.i_redirect_pc & ~32'h3;
    assign update_tgt  = bus.i_update_target & ~32'h3;
    assign unused_low_bits = ^bus.i_update_pc[1:0];

    assign lk_idx      = pc_q[IDX_W+1:2];
    assign lk_tag      = pc_q[31:IDX_W+2];
    assign lk_hit      = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && btb_ctr_q[lk_idx][1];
    // The target is only reported for a taken prediction, so invalid entries never leak X.
    assign pred_target = pred_taken ? {btb_tgt_q[lk_idx], 2'b00} : 32'h0;

    assign up_idx = bus.i_update_pc[IDX_W+1:2];
    assign up_tag = bus.i_update_pc[31:IDX_W+2];
    assign up_hit = btb_vld_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    always_comb begin
        up_ctr_d = btb_ctr_q[up_idx];
        if (bus.i_update_taken) begin
            if (btb_ctr_q[up_idx] != 2'b11) up_ctr_d = btb_ctr_q[up_idx] + 2'b01;
        end else begin
            if (btb_ctr_q[up_idx] != 2'b00) up_ctr_d = btb_ctr_q[up_idx] - 2'b01;
        end
    end

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (bus.i_redirect_execute) pc_d = redirect_pc;
        else if (bus.i_stall_fetch) pc_d = pc_q;
        else if (pred_taken)        pc_d = pred_target;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) pc_q <= RESET_PC & ~32'h3;
        else         pc_q <= pc_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            btb_vld_q <= '0;
        end else if (bus.i_update_vld && !up_hit && bus.i_update_taken) begin
            btb_vld_q[up_idx] <= 1'b1;
        end
    end

    // Payload fields carry no reset; the cleared valid bits make them unreachable.
    always_ff @(posedge i_clk) begin
        if (!i_reset && bus.i_update_vld) begin
            if (up_hit) begin
                btb_ctr_q[up_idx] <= up_ctr_d;
                if (bus.i_update_taken) btb_tgt_q[up_idx] <= update_tgt[31:2];
            end else if (bus.i_update_taken) begin
                btb_tag_q[up_idx] <= up_tag;
                btb_tgt_q[up_idx] <= update_tgt[31:2];
                btb_ctr_q[up_idx] <= 2'b10;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_redirect_execute || bus.i_flush_decode) begin
            dec_pc_q    <= 32'h0;
            dec_instr_q <= NOP;
            dec_pt_q    <= 1'b0;
            dec_tgt_q   <= 32'h0;
            dec_vld_q   <= 1'b0;
        end else if (!bus.i_stall_fetch) begin
            dec_pc_q    <= pc_q;
            dec_instr_q <= bus.i_imem_rdata;
            dec_pt_q    <= pred_taken;
            dec_tgt_q   <= pred_target;
            dec_vld_q   <= 1'b1;
        end
    end

    assign bus.o_imem_addr          = pc_q;
    assign bus.o_pc_decode          = dec_pc_q;
    assign bus.o_instr_decode       = dec_instr_q;
    assign bus.o_pred_taken_decode  = dec_pt_q;
    assign bus.o_pred_target_decode = dec_tgt_q;
    assign bus.o_insn_vld_decode    = dec_vld_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all checked
// against a behavioural model of the PC, the predictor table and the decode register.
module tb_fetch_stage;
    localparam int          N        = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    bit   fixed_mode;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.BTB_ENTRIES(N), .RESET_PC(RESET_PC)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [31:0] scramble(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.i_imem_rdata = fixed_mode ? 32'h00A0_0093 : scramble(bus.o_imem_addr);

    // Model state: the table is keyed by full word address rather than by index/tag split.
    logic [31:0] m_pc;
    logic [31:0] m_dec_pc, m_dec_instr, m_dec_tgt;
    bit          m_dec_pt, m_dec_vld;
    bit          m_vld [N];
    logic [31:0] m_key [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit red, input logic [31:0] rpc, input bit st,
                              input bit fl, input bit uv, input logic [31:0] upc,
                              input bit ut, input logic [31:0] utgt);
        int          li, ui;
        bit          pt;
        logic [31:0] ptgt, instr, nxt;
        li    = int'((m_pc >> 2) % N);
        pt    = m_vld[li] && (m_key[li] == m_pc) && (m_ctr[li] >= 2);
        ptgt  = pt ? m_tgt[li] : 32'h0;
        instr = fixed_mode ? 32'h00A0_0093 : scramble(m_pc);

        if (r)        nxt = RESET_PC & ~32'h3;
        else if (red) nxt = rpc & ~32'h3;
        else if (st)  nxt = m_pc;
        else if (pt)  nxt = ptgt;
        else          nxt = m_pc + 32'd4;

        if (r || red || fl) begin
            m_dec_pc = 0; m_dec_instr = 32'h13; m_dec_pt = 0; m_dec_tgt = 0; m_dec_vld = 0;
        end else if (!st) begin
            m_dec_pc = m_pc; m_dec_instr = instr; m_dec_pt = pt; m_dec_tgt = ptgt; m_dec_vld = 1;
        end

        if (r) begin
            for (int i = 0; i < N; i++) m_vld[i] = 0;
        end else if (uv) begin
            ui = int'((upc >> 2) % N);
            if (m_vld[ui] && m_key[ui] == (upc & ~32'h3)) begin
                m_ctr[ui] = ut ? ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1)
                               : ((m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1);
                if (ut) m_tgt[ui] = utgt & ~32'h3;
            end else if (ut) begin
                m_vld[ui] = 1;
                m_key[ui] = upc & ~32'h3;
                m_tgt[ui] = utgt & ~32'h3;
                m_ctr[ui] = 2;
            end
        end
        m_pc = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic check_all();
        check("imem_addr",   bus.o_imem_addr, exp_q.pop_front());
        check("dec_pc",      bus.o_pc_decode, m_dec_pc);
        check("dec_instr",   bus.o_instr_decode, m_dec_instr);
        check("dec_pt",      {31'b0, bus.o_pred_taken_decode}, {31'b0, m_dec_pt});
        check("dec_tgt",     bus.o_pred_target_decode, m_dec_tgt);
        check("dec_vld",     {31'b0, bus.o_insn_vld_decode}, {31'b0, m_dec_vld});
    endtask

    task automatic cycle(input bit r, input bit red, input logic [31:0] rpc, input bit st,
                         input bit fl, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt);
        rst                    = r;
        bus.i_redirect_execute = red;
        bus.i_redirect_pc      = rpc;
        bus.i_stall_fetch      = st;
        bus.i_flush_decode     = fl;
        bus.i_update_vld       = uv;
        bus.i_update_pc        = upc;
        bus.i_update_taken     = ut;
        bus.i_update_target    = utgt;
        model_step(r, red, rpc, st, fl, uv, upc, ut, utgt);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input logic [31:0] rpc);
        cycle(0, 1, rpc, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] rpc, upc, utgt;
        bit          r, red, st, fl, uv, ut;
        fixed_mode = 1;
        m_pc = 0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_addr", bus.o_imem_addr, RESET_PC);
        check("rst_vld", {31'b0, bus.o_insn_vld_decode}, 32'h0);
        check("rst_instr", bus.o_instr_decode, 32'h13);

        // Three free-running fetches after reset.
        idle(); check("seq_pc0", bus.o_pc_decode, 32'h0);
        check("seq_instr", bus.o_instr_decode, 32'h00A0_0093);
        idle(); check("seq_pc4", bus.o_pc_decode, 32'h4);
        idle(); check("seq_pc8", bus.o_pc_decode, 32'h8);
        check("seq_pt", {31'b0, bus.o_pred_taken_decode}, 32'h0);

        // Allocate 0x10 -> 0x40, then fetch 0x10.
        cycle(0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h40);
        check("alloc_addr", bus.o_imem_addr, 32'h10);
        idle();
        check("pred_addr", bus.o_imem_addr, 32'h40);
        check("pred_pt", {31'b0, bus.o_pred_taken_decode}, 32'h1);
        check("pred_tgt", bus.o_pred_target_decode, 32'h40);

        // Train 0x10 down to strongly not-taken.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1, 32'h10, 0, 32'h0);
        redirect(32'h10);
        idle();
        check("nt_addr", bus.o_imem_addr, 32'h14);
        check("nt_pt", {31'b0, bus.o_pred_taken_decode}, 32'h0);

        // Stall at 0x8, then stall together with a redirect.
        redirect(32'h4);
        idle();
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("stall_addr", bus.o_imem_addr, 32'h8);
        check("stall_dec_pc", bus.o_pc_decode, 32'h4);
        check("stall_dec_vld", {31'b0, bus.o_insn_vld_decode}, 32'h1);
        cycle(0, 1, 32'h100, 1, 0, 0, 0, 0, 0);
        check("stall_red_addr", bus.o_imem_addr, 32'h100);
        check("stall_red_instr", bus.o_instr_decode, 32'h13);
        check("stall_red_vld", {31'b0, bus.o_insn_vld_decode}, 32'h0);

        // Wrap of the PC at the top of the address space.
        redirect(32'hFFFF_FFFE);
        check("wrap_mask", bus.o_imem_addr, 32'hFFFF_FFFC);
        idle();
        check("wrap_addr", bus.o_imem_addr, 32'h0);

        // Reset wins over redirect and a taken update.
        cycle(1, 1, 32'h200, 0, 0, 1, 32'h20, 1, 32'h80);
        check("rst_win_addr", bus.o_imem_addr, RESET_PC);
        redirect(32'h20);
        idle();
        check("rst_win_nopred", bus.o_imem_addr, 32'h24);

        // Random traffic.
        fixed_mode = 0;
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            red = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            uv  = ($urandom_range(0, 2) == 0);
            ut  = ($urandom_range(0, 2) != 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255))
                                              : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            upc = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) upc = upc | 32'h0000_1000;
            utgt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            cycle(r, red, rpc, st, fl, uv, upc, ut, utgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
